pp_wavefront_scheduler: RTL and testbench

Parameterised sequencer for the concurrent error-diffusion halftone converter. It replaces the fixed per-state index table with counter-driven wavefront scheduling: image row r goes to pixel-processor lane (r-1) mod P_NUM, and each row starts two steps after the row above it. Each cycle it produces a 1-based (col, row) address per lane, plus the image-load and value-load strobes for the pixel memory unit. It sits between the top-level Go/Done interface and the memory/datapath lanes.

---
 rtl/pp_sched_pkg.sv | 29 ++
 rtl/pp_lane_tracker.sv | 87 ++++++++
 rtl/pp_wavefront_scheduler.sv | 121 ++++++++++++
 tb/tb_pp_wavefront_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_sched_pkg.sv
// Shared types and elaboration-time helpers for the wavefront scheduler.
// Sizes the counters and checks which lane counts are legal for a given image size.
package pp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Ceiling log2 with a floor of one bit so degenerate sizes still get a register.
  function automatic int width_f(input int v);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < v) w = w + 1;
    return w;
  endfunction

  function automatic int steps_f(input int n_col, input int m_row);
    return 2 * (m_row - 1) + n_col;
  endfunction

  // A lane must finish a row before its next row (2*P_NUM steps later) begins.
  function automatic bit legal_f(input int n_col, input int p_num);
    return (n_col <= 2 * p_num);
  endfunction

endpackage

// File: rtl/pp_lane_tracker.sv
// One pixel-processor lane: walks the columns of each row assigned to it,
// starting a row when the global step reaches that row's wavefront offset.
module pp_lane_tracker
  import pp_sched_pkg::*;
#(
  parameter int N_COL = 8,
  parameter int M_ROW = 6,
  parameter int P_NUM = 4,
  parameter int LANE  = 0,
  parameter int COL_W = 4,
  parameter int ROW_W = 3,
  parameter int T_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [T_W-1:0]   step_i,
  output logic             valid_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o
);
  localparam int NR_W = width_f(M_ROW + P_NUM + 1);
  localparam logic [NR_W-1:0]  FIRST_ROW = NR_W'(LANE + 1);
  localparam logic [NR_W-1:0]  LAST_ROW  = NR_W'(M_ROW);
  localparam logic [NR_W-1:0]  STRIDE    = NR_W'(P_NUM);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(N_COL);

  logic             active_q, active_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [NR_W-1:0]  nxt_q, nxt_d;
  logic [T_W:0]     off_s;
  logic             start_s;

  assign off_s   = (T_W+1)'({nxt_q - NR_W'(1), 1'b0});
  assign start_s = (nxt_q <= LAST_ROW) && (off_s == {1'b0, step_i});

  // Lane state register
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      col_q    <= {COL_W{1'b0}};
      row_q    <= {ROW_W{1'b0}};
      nxt_q    <= FIRST_ROW;
    end else begin
      active_q <= active_d;
      col_q    <= col_d;
      row_q    <= row_d;
      nxt_q    <= nxt_d;
    end
  end

  // Continue the current row, open the next one, or go idle
  always_comb begin
    active_d = active_q;
    col_d    = col_q;
    row_d    = row_q;
    nxt_d    = nxt_q;
    if (clr_i) begin
      active_d = 1'b0;
      col_d    = {COL_W{1'b0}};
      row_d    = {ROW_W{1'b0}};
      nxt_d    = FIRST_ROW;
    end else if (adv_i) begin
      if (active_q && (col_q != COL_MAX)) begin
        col_d = col_q + COL_W'(1);
      end else if (start_s) begin
        active_d = 1'b1;
        col_d    = COL_W'(1);
        row_d    = ROW_W'(nxt_q);
        nxt_d    = nxt_q + STRIDE;
      end else begin
        active_d = 1'b0;
        col_d    = {COL_W{1'b0}};
        row_d    = {ROW_W{1'b0}};
      end
    end else begin
      nxt_d = nxt_q;
    end
  end

  assign valid_o = active_q;
  assign col_o   = col_q;
  assign row_o   = row_q;

endmodule

// File: rtl/pp_wavefront_scheduler.sv
// Go/Done sequencer for the error-diffusion halftone lanes: row r runs on lane
// (r-1) mod P_NUM, each row trailing the one above by two steps.
module pp_wavefront_scheduler
  import pp_sched_pkg::*;
#(
  parameter int N_COL = 8,
  parameter int M_ROW = 6,
  parameter int P_NUM = 4,
  localparam int COL_W = width_f(N_COL + 1),
  localparam int ROW_W = width_f(M_ROW + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   hold_i,
  output logic                   ready_o,
  output logic                   ld_image_o,
  output logic                   ld_values_o,
  output logic                   done_o,
  output logic [P_NUM-1:0]       lane_valid_o,
  output logic [P_NUM*COL_W-1:0] lane_col_o,
  output logic [P_NUM*ROW_W-1:0] lane_row_o
);
  localparam int T_STEPS = steps_f(N_COL, M_ROW);
  localparam int T_W     = width_f(T_STEPS);
  localparam logic [T_W-1:0] T_LAST = T_W'(T_STEPS - 1);

  if (!legal_f(N_COL, P_NUM)) begin : g_illegal
    $error("pp_wavefront_scheduler: N_COL must not exceed 2*P_NUM");
  end

  state_e         state_q, state_d;
  logic [T_W-1:0] t_q, t_d, step_nxt_s;
  logic           ready_q, ready_d, ld_image_q, ld_image_d, done_q, done_d;
  logic           lane_clr_s, lane_adv_s;

  // State, step counter and registered strobes
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      t_q        <= {T_W{1'b0}};
      ready_q    <= 1'b1;
      ld_image_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      ready_q    <= ready_d;
      ld_image_q <= ld_image_d;
      done_q     <= done_d;
    end
  end

  // Next state and step
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        t_d     = {T_W{1'b0}};
      end
      ST_RUN: begin
        if (hold_i) begin
          state_d = ST_RUN;
        end else if (t_q == T_LAST) begin
          state_d = ST_FIN;
          t_d     = {T_W{1'b0}};
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes for the next cycle, lane control, and the write-back gate
  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    ld_image_d = (state_d == ST_LOAD);
    done_d     = (state_d == ST_FIN);
    lane_clr_s = (state_d != ST_RUN);
    lane_adv_s = 1'b0;
    step_nxt_s = {T_W{1'b0}};
    if (state_q == ST_LOAD) begin
      lane_adv_s = 1'b1;
    end else if ((state_q == ST_RUN) && !hold_i) begin
      lane_adv_s = 1'b1;
      step_nxt_s = t_q + T_W'(1);
    end else begin
      lane_adv_s = 1'b0;
    end
    ld_values_o = (state_q == ST_RUN) && (|lane_valid_o) && !hold_i;
  end

  for (genvar p = 0; p < P_NUM; p++) begin : g_lane
    pp_lane_tracker #(
      .N_COL(N_COL), .M_ROW(M_ROW), .P_NUM(P_NUM), .LANE(p),
      .COL_W(COL_W), .ROW_W(ROW_W), .T_W(T_W)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .clr_i  (lane_clr_s),
      .adv_i  (lane_adv_s),
      .step_i (step_nxt_s),
      .valid_o(lane_valid_o[p]),
      .col_o  (lane_col_o[p*COL_W +: COL_W]),
      .row_o  (lane_row_o[p*ROW_W +: ROW_W])
    );
  end

  assign ready_o    = ready_q;
  assign ld_image_o = ld_image_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_pp_wavefront_scheduler.sv
// Directed bench for pp_wavefront_scheduler: default 8x6/4 instance plus a 5x3/3 instance.
module tb_pp_wavefront_scheduler;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_n, start_i, hold_i, start2_i;
  logic        ready_o, ld_image_o, ld_values_o, done_o;
  logic [3:0]  lane_valid_o;
  logic [15:0] lane_col_o;
  logic [11:0] lane_row_o;
  logic        ready2, ld_image2, ld_values2, done2;
  logic [2:0]  valid2;
  logic [8:0]  col2;
  logic [5:0]  row2;

  int checks = 0;
  int errors = 0;

  pp_wavefront_scheduler #(.N_COL(8), .M_ROW(6), .P_NUM(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .hold_i(hold_i),
    .ready_o(ready_o), .ld_image_o(ld_image_o), .ld_values_o(ld_values_o), .done_o(done_o),
    .lane_valid_o(lane_valid_o), .lane_col_o(lane_col_o), .lane_row_o(lane_row_o)
  );

  pp_wavefront_scheduler #(.N_COL(5), .M_ROW(3), .P_NUM(3)) dut2 (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start2_i), .hold_i(1'b0),
    .ready_o(ready2), .ld_image_o(ld_image2), .ld_values_o(ld_values2), .done_o(done2),
    .lane_valid_o(valid2), .lane_col_o(col2), .lane_row_o(row2)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference wavefront: which row (if any) lane p serves at step t.
  function automatic void model(input int t, input int p, input int nc, input int mr, input int pn,
                                output logic v, output int c, output int r);
    v = 1'b0; c = 0; r = 0;
    for (int rr = 1; rr <= mr; rr++) begin
      if (((rr - 1) % pn) == p && (t - 2*(rr-1)) >= 0 && (t - 2*(rr-1)) < nc) begin
        v = 1'b1; c = t - 2*(rr-1) + 1; r = rr;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; hold_i = 1'b0; start2_i = 1'b0;
    tick(); tick();
    checks++;
    if (ready_o !== 1'b1 || ld_image_o !== 1'b0 || ld_values_o !== 1'b0 || done_o !== 1'b0 ||
        lane_valid_o !== 4'b0 || lane_col_o !== 16'b0 || lane_row_o !== 12'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b ldi=%b ldv=%b done=%b v=%b col=%h row=%h want rdy=1 rest=0",
               ready_o, ld_image_o, ld_values_o, done_o, lane_valid_o, lane_col_o, lane_row_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1 || ready2 !== 1'b1 || lane_valid_o !== 4'b0 || valid2 !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b rdy2=%b v=%b v2=%b want 1 1 0 0",
               ready_o, ready2, lane_valid_o, valid2);
    end
  endtask

  task automatic test_full_run(input string tag);
    logic v; int c, r, nvalid, dups;
    bit seen [1:8][1:6];
    int dcol [4] = '{1, 7, 5, 3};
    int drow [4] = '{5, 2, 3, 4};
    nvalid = 0; dups = 0;
    for (int i = 1; i <= 8; i++) for (int j = 1; j <= 6; j++) seen[i][j] = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (ld_image_o !== 1'b1 || ready_o !== 1'b0 || lane_valid_o !== 4'b0) begin
      errors++;
      $display("FAIL %s load: got ldi=%b rdy=%b v=%b want 1 0 0", tag, ld_image_o, ready_o, lane_valid_o);
    end
    for (int t = 0; t < 18; t++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        model(t, p, 8, 6, 4, v, c, r);
        checks++;
        if (lane_valid_o[p] !== v || int'(lane_col_o[p*4 +: 4]) != c || int'(lane_row_o[p*3 +: 3]) != r) begin
          errors++;
          $display("FAIL %s step%0d lane%0d: got v=%b c=%0d r=%0d want v=%b c=%0d r=%0d", tag, t, p,
                   lane_valid_o[p], lane_col_o[p*4 +: 4], lane_row_o[p*3 +: 3], v, c, r);
        end
        if (lane_valid_o[p] === 1'b1) begin
          nvalid++;
          if (lane_col_o[p*4 +: 4] >= 4'd1 && lane_col_o[p*4 +: 4] <= 4'd8 &&
              lane_row_o[p*3 +: 3] >= 3'd1 && lane_row_o[p*3 +: 3] <= 3'd6) begin
            if (seen[lane_col_o[p*4 +: 4]][lane_row_o[p*3 +: 3]]) dups++;
            seen[lane_col_o[p*4 +: 4]][lane_row_o[p*3 +: 3]] = 1'b1;
          end else begin
            dups++;
          end
        end
      end
      checks++;
      if (ld_values_o !== 1'b1 || done_o !== 1'b0 || ld_image_o !== 1'b0) begin
        errors++;
        $display("FAIL %s strobes step%0d: got ldv=%b done=%b ldi=%b want 1 0 0", tag, t, ld_values_o, done_o, ld_image_o);
      end
      if (t == 0) begin
        checks++;
        if (lane_valid_o !== 4'b0001 || lane_col_o[3:0] !== 4'd1 || lane_row_o[2:0] !== 3'd1) begin
          errors++;
          $display("FAIL %s step0: got v=%b c=%0d r=%0d want 0001 1 1", tag, lane_valid_o, lane_col_o[3:0], lane_row_o[2:0]);
        end
      end
      if (t == 8) begin
        for (int p = 0; p < 4; p++) begin
          checks++;
          if (lane_valid_o[p] !== 1'b1 || int'(lane_col_o[p*4 +: 4]) != dcol[p] || int'(lane_row_o[p*3 +: 3]) != drow[p]) begin
            errors++;
            $display("FAIL %s wavefront8 lane%0d: got (%0d,%0d) want (%0d,%0d)", tag, p,
                     lane_col_o[p*4 +: 4], lane_row_o[p*3 +: 3], dcol[p], drow[p]);
          end
        end
      end
      if (t == 17) begin
        checks++;
        if (lane_valid_o !== 4'b0010 || lane_col_o[7:4] !== 4'd8 || lane_row_o[5:3] !== 3'd6) begin
          errors++;
          $display("FAIL %s step17: got v=%b (%0d,%0d) want 0010 (8,6)", tag, lane_valid_o, lane_col_o[7:4], lane_row_o[5:3]);
        end
      end
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || lane_valid_o !== 4'b0 || ld_values_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle20: got done=%b v=%b ldv=%b rdy=%b want 1 0 0 0", tag, done_o, lane_valid_o, ld_values_o, ready_o);
    end
    checks++;
    if (nvalid != 48 || dups != 0) begin
      errors++;
      $display("FAIL %s coverage: got %0d lane-cycles %0d dups want 48 0", tag, nvalid, dups);
    end
    tick();
    checks++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: got rdy=%b done=%b want 1 0", tag, ready_o, done_o);
    end
  endtask

  task automatic test_hold();
    logic v; int c, r, et;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int cyc = 2; cyc <= 24; cyc++) begin
      tick();
      hold_i = (cyc >= 7 && cyc <= 9);
      #1;
      et = (cyc <= 7) ? cyc - 2 : ((cyc <= 10) ? 5 : cyc - 5);
      if (cyc <= 22) begin
        for (int p = 0; p < 4; p++) begin
          model(et, p, 8, 6, 4, v, c, r);
          checks++;
          if (lane_valid_o[p] !== v || int'(lane_col_o[p*4 +: 4]) != c || int'(lane_row_o[p*3 +: 3]) != r) begin
            errors++;
            $display("FAIL hold cyc%0d lane%0d: got v=%b c=%0d r=%0d want v=%b c=%0d r=%0d", cyc, p,
                     lane_valid_o[p], lane_col_o[p*4 +: 4], lane_row_o[p*3 +: 3], v, c, r);
          end
        end
        checks++;
        if (ld_values_o !== !hold_i || done_o !== 1'b0) begin
          errors++;
          $display("FAIL hold_strobe cyc%0d: got ldv=%b done=%b want %b 0", cyc, ld_values_o, done_o, !hold_i);
        end
      end else begin
        checks++;
        if (done_o !== (cyc == 23)) begin
          errors++;
          $display("FAIL hold_done cyc%0d: got done=%b want %b", cyc, done_o, (cyc == 23));
        end
      end
    end
    hold_i = 1'b0;
  endtask

  task automatic test_start_held();
    start_i = 1'b1;
    for (int cyc = 1; cyc <= 42; cyc++) begin
      tick();
      if (cyc == 23) start_i = 1'b0;
      checks++;
      if (ld_image_o !== (cyc == 1 || cyc == 22) || done_o !== (cyc == 20 || cyc == 41)) begin
        errors++;
        $display("FAIL start_held cyc%0d: got ldi=%b done=%b want %b %b", cyc, ld_image_o, done_o,
                 (cyc == 1 || cyc == 22), (cyc == 20 || cyc == 41));
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset_midrun();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int cyc = 2; cyc <= 11; cyc++) tick();
    checks++;
    if (lane_valid_o !== 4'b1111 || lane_col_o[3:0] !== 4'd2) begin
      errors++;
      $display("FAIL midrun_step9: got v=%b c0=%0d want 1111 2", lane_valid_o, lane_col_o[3:0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (ready_o !== 1'b1 || lane_valid_o !== 4'b0 || lane_col_o !== 16'b0 || lane_row_o !== 12'b0 ||
        ld_image_o !== 1'b0 || done_o !== 1'b0 || ld_values_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b v=%b col=%h row=%h ldi=%b done=%b ldv=%b want 1 and zeros",
               ready_o, lane_valid_o, lane_col_o, lane_row_o, ld_image_o, done_o, ld_values_o);
    end
    test_full_run("after_reset");
  endtask

  task automatic test_small_config();
    logic v; int c, r;
    start2_i = 1'b1;
    tick();
    start2_i = 1'b0;
    checks++;
    if (ld_image2 !== 1'b1) begin
      errors++;
      $display("FAIL small_load: got ldi=%b want 1", ld_image2);
    end
    for (int cyc = 2; cyc <= 12; cyc++) begin
      tick();
      if (cyc <= 10) begin
        for (int p = 0; p < 3; p++) begin
          model(cyc - 2, p, 5, 3, 3, v, c, r);
          checks++;
          if (valid2[p] !== v || int'(col2[p*3 +: 3]) != c || int'(row2[p*2 +: 2]) != r) begin
            errors++;
            $display("FAIL small step%0d lane%0d: got v=%b c=%0d r=%0d want v=%b c=%0d r=%0d", cyc - 2, p,
                     valid2[p], col2[p*3 +: 3], row2[p*2 +: 2], v, c, r);
          end
        end
      end
      checks++;
      if (done2 !== (cyc == 11) || ready2 !== (cyc == 12)) begin
        errors++;
        $display("FAIL small_done cyc%0d: got done=%b rdy=%b want %b %b", cyc, done2, ready2, (cyc == 11), (cyc == 12));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run("default");
    test_hold();
    test_start_held();
    test_reset_midrun();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
